// File: rtl/lsu_mem_if_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// lsu_mem_if_pkg : funct3 access-size encodings and LSU state type
// Rev 1.0
// ----------------------------------------------------------------------------
package lsu_mem_if_pkg;

  localparam int BYTE_LANES = 4;

  localparam logic [2:0] MEM_SIZE_B  = 3'b000;
  localparam logic [2:0] MEM_SIZE_H  = 3'b001;
  localparam logic [2:0] MEM_SIZE_W  = 3'b010;
  localparam logic [2:0] MEM_SIZE_BU = 3'b100;
  localparam logic [2:0] MEM_SIZE_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2,
    ST_DONE = 2'd3
  } lsu_state_e;

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ----------------------------------------------------------------------------
// lsu_align : byte-lane steering, byte enables, load extension and size checks
// Rev 1.0
// ----------------------------------------------------------------------------
module lsu_align
  import lsu_mem_if_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [2:0]            size,
  input  logic [1:0]            addr_lo,
  input  logic                  write,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W-1:0]     rdata,
  output logic [BYTE_LANES-1:0] be,
  output logic [DATA_W-1:0]     wdata_steer,
  output logic [DATA_W-1:0]     rdata_ext,
  output logic                  misalign,
  output logic                  illegal
);

  logic [DATA_W-1:0] rdata_sh;

  // Addressed byte moved down to lane 0 before extension
  assign rdata_sh = rdata >> {addr_lo, 3'b000};

  always_comb begin
    be          = '0;
    wdata_steer = wdata;
    rdata_ext   = rdata_sh;
    misalign    = 1'b0;
    illegal     = 1'b0;
    case (size)
      MEM_SIZE_B, MEM_SIZE_BU: begin
        be          = 4'b0001 << addr_lo;
        wdata_steer = {(DATA_W/8){wdata[7:0]}};
        rdata_ext   = (size == MEM_SIZE_B) ?
                      {{(DATA_W-8){rdata_sh[7]}}, rdata_sh[7:0]} :
                      {{(DATA_W-8){1'b0}}, rdata_sh[7:0]};
      end
      MEM_SIZE_H, MEM_SIZE_HU: begin
        be          = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_steer = {(DATA_W/16){wdata[15:0]}};
        rdata_ext   = (size == MEM_SIZE_H) ?
                      {{(DATA_W-16){rdata_sh[15]}}, rdata_sh[15:0]} :
                      {{(DATA_W-16){1'b0}}, rdata_sh[15:0]};
        misalign    = addr_lo[0];
      end
      MEM_SIZE_W: begin
        be       = 4'b1111;
        misalign = |addr_lo;
      end
      default: illegal = 1'b1;
    endcase
    // Unsigned sizes only exist for loads
    if (size[2] && write) illegal = 1'b1;
  end

endmodule
`default_nettype wire

// File: rtl/lsu_mem_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// lsu_mem_if : memory-stage load/store responder on a valid/ready data bus
// Rev 1.0
// ----------------------------------------------------------------------------
module lsu_mem_if
  import lsu_mem_if_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [2:0]        req_size,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              stall,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              misalign,
  output logic              fault,
  output logic              bus_req_valid,
  input  logic              bus_req_ready,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_be,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_resp_valid,
  input  logic              bus_resp_err,
  input  logic [DATA_W-1:0] bus_rdata
);

  localparam int          CNT_W   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT - 1);

  lsu_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        size_q, size_d;
  logic              write_q, write_d;
  logic [1:0]        addr_lo_q, addr_lo_d;
  logic              bus_req_valid_q, bus_req_valid_d;
  logic              bus_we_q, bus_we_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [3:0]        bus_be_q, bus_be_d;
  logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              fault_q, fault_d;

  logic              is_idle;
  logic [2:0]        size_sel;
  logic [1:0]        addr_lo_sel;
  logic              write_sel;
  logic [3:0]        algn_be;
  logic [DATA_W-1:0] algn_wdata;
  logic [DATA_W-1:0] algn_rdata;
  logic              algn_misalign;
  logic              algn_illegal;
  logic              accept;
  logic              timeout_hit;

  assign is_idle = (state_q == ST_IDLE);

  // The aligner sees the live request in IDLE and the latched access afterwards
  assign size_sel    = is_idle ? req_size      : size_q;
  assign addr_lo_sel = is_idle ? req_addr[1:0] : addr_lo_q;
  assign write_sel   = is_idle ? req_write     : write_q;

  lsu_align #(
    .DATA_W (DATA_W)
  ) u_align (
    .size        (size_sel),
    .addr_lo     (addr_lo_sel),
    .write       (write_sel),
    .wdata       (req_wdata),
    .rdata       (bus_rdata),
    .be          (algn_be),
    .wdata_steer (algn_wdata),
    .rdata_ext   (algn_rdata),
    .misalign    (algn_misalign),
    .illegal     (algn_illegal)
  );

  assign accept      = is_idle && req_valid && !algn_illegal && !algn_misalign;
  assign timeout_hit = (TIMEOUT != 0) && (32'(cnt_q) == TO_LAST);

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    size_d          = size_q;
    write_d         = write_q;
    addr_lo_d       = addr_lo_q;
    bus_req_valid_d = bus_req_valid_q;
    bus_we_d        = bus_we_q;
    bus_addr_d      = bus_addr_q;
    bus_be_d        = bus_be_q;
    bus_wdata_d     = bus_wdata_q;
    rd_data_d       = rd_data_q;
    rd_valid_d      = 1'b0;
    fault_d         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d         = ST_REQ;
          size_d          = req_size;
          write_d         = req_write;
          addr_lo_d       = req_addr[1:0];
          bus_req_valid_d = 1'b1;
          bus_we_d        = req_write;
          bus_addr_d      = {req_addr[ADDR_W-1:2], 2'b00};
          bus_be_d        = algn_be;
          bus_wdata_d     = algn_wdata;
        end
      end
      ST_REQ: begin
        if (bus_req_ready) begin
          state_d         = ST_RESP;
          bus_req_valid_d = 1'b0;
          cnt_d           = '0;
        end
      end
      ST_RESP: begin
        cnt_d = cnt_q + CNT_W'(1);
        // A response in the last allowed cycle still wins over the timeout
        if (bus_resp_valid) begin
          state_d = ST_DONE;
          if (bus_resp_err) begin
            fault_d = 1'b1;
          end else if (!write_q) begin
            rd_data_d  = algn_rdata;
            rd_valid_d = 1'b1;
          end
        end else if (timeout_hit) begin
          state_d = ST_DONE;
          fault_d = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      cnt_q           <= '0;
      size_q          <= '0;
      write_q         <= 1'b0;
      addr_lo_q       <= '0;
      bus_req_valid_q <= 1'b0;
      bus_we_q        <= 1'b0;
      bus_addr_q      <= '0;
      bus_be_q        <= '0;
      bus_wdata_q     <= '0;
      rd_data_q       <= '0;
      rd_valid_q      <= 1'b0;
      fault_q         <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      size_q          <= size_d;
      write_q         <= write_d;
      addr_lo_q       <= addr_lo_d;
      bus_req_valid_q <= bus_req_valid_d;
      bus_we_q        <= bus_we_d;
      bus_addr_q      <= bus_addr_d;
      bus_be_q        <= bus_be_d;
      bus_wdata_q     <= bus_wdata_d;
      rd_data_q       <= rd_data_d;
      rd_valid_q      <= rd_valid_d;
      fault_q         <= fault_d;
    end
  end

  // Rejected accesses report in the same IDLE cycle; bus-side faults show up in DONE
  assign stall         = accept || (state_q == ST_REQ) || (state_q == ST_RESP);
  assign misalign      = is_idle && req_valid && !algn_illegal && algn_misalign;
  assign fault         = fault_q || (is_idle && req_valid && algn_illegal);
  assign rd_valid      = rd_valid_q;
  assign rd_data       = rd_data_q;
  assign bus_req_valid = bus_req_valid_q;
  assign bus_we        = bus_we_q;
  assign bus_addr      = bus_addr_q;
  assign bus_be        = bus_be_q;
  assign bus_wdata     = bus_wdata_q;

endmodule
`default_nettype wire

// File: doc/lsu_mem_if.md
Name: lsu_mem_if

Overview:
- Memory-stage responder for the control fields the main decoder issues: `mem_to_reg`, `mem_write` and `mem_size` (funct3).
- Turns one load or store per instruction into a valid/ready request plus a response on the data-memory bus.
- Stalls the pipeline until the access completes.
- Performs byte-lane steering and byte enables for stores, and sign/zero extension for loads.
- Detects misalignment, illegal size, bus error and timeout.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width (fixed 4 byte lanes).
- TIMEOUT, 255, maximum wait in RESP before fault; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  MEM-stage instruction is a load or store (`mem_to_reg` or `mem_write`)
- req_write  in  1  1 = store
- req_size  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  in  ADDR_W  ALU result
- req_wdata  in  DATA_W  rs2 value
- stall  out  1  hold the pipeline
- rd_data  out  DATA_W  extended load result
- rd_valid  out  1  one-cycle load result strobe
- misalign  out  1  one-cycle misaligned-access pulse
- fault  out  1  one-cycle illegal size / bus error / timeout pulse
- bus_req_valid  out  1
- bus_req_ready  in  1
- bus_we  out  1
- bus_addr  out  ADDR_W  word-aligned, bits [1:0] = 0
- bus_be  out  4
- bus_wdata  out  DATA_W
- bus_resp_valid  in  1
- bus_resp_err  in  1
- bus_rdata  in  DATA_W

Behaviour:
- Reset values: state IDLE; all outputs 0; timeout counter 0.
- Reset mid-operation drops the access immediately; bus_req_valid falls asynchronously.
- States: IDLE, REQ, RESP, DONE.
- IDLE:
  - stall = req_valid, combinational.
  - Illegal size (011, 110, 111, or 1xx with req_write): pulse fault, stall = 0, no bus access, stay IDLE.
  - Misaligned (H with addr[0] = 1; W with addr[1:0] != 0): pulse misalign, stall = 0, stay IDLE.
  - Otherwise: latch addr, be, wdata, size, write; go to REQ.
- REQ:
  - bus_req_valid = 1; all bus_* fields held stable until bus_req_ready.
  - Handshake when valid and ready are both 1; then go to RESP and clear the counter.
- RESP:
  - Wait for bus_resp_valid; stores also receive an ack response.
  - resp_err = 1: pulse fault, rd_valid = 0, go to DONE.
  - Otherwise capture the extended load data into rd_data, go to DONE.
  - Counter increments each cycle. When it reaches TIMEOUT (and TIMEOUT != 0): pulse fault, go to DONE.
- DONE:
  - stall = 0; rd_valid = 1 for a successful load; go to IDLE.
  - The pipeline advances at the end of this cycle.
  - rd_data holds its value until the next load completes.
- Stall: 1 in IDLE (when req_valid and the access is legal and aligned), REQ and RESP; 0 in DONE.
- Minimum latency with zero-wait memory: 3 stall cycles; result in cycle 3 (cycles 0 IDLE, 1 REQ, 2 RESP, 3 DONE).
- bus_resp_valid in IDLE, REQ or DONE is ignored; this covers a stale response after reset.
- req_* inputs are sampled only in IDLE.
- Byte enables:
  - B: `4'b0001 << addr[1:0]`
  - H: 0011 if addr[1] = 0, else 1100
  - W: 1111
- bus_wdata: byte replicated 4x; half replicated 2x; word unchanged.
- Load path: `bus_rdata >> (8*addr[1:0])`, then:
  - B / H: sign-extend from bit 7 / 15.
  - BU / HU: zero-extend.

Decomposition:
- Shared include, alongside the existing opcode/const includes:
  - MEM_SIZE_B/H/W/BU/HU encodings.
  - LSU state encodings (IDLE = 0, REQ = 1, RESP = 2, DONE = 3).
- One combinational sub-module, lsu_align:
  - Inputs: size, addr[1:0], wdata, rdata.
  - Outputs: be, steered wdata, extended rdata, misalign, illegal.
  - The FSM stays in lsu_mem_if.

Test Plan:
- LW, addr 0x100, zero-wait memory, rdata 0xDEADBEEF -> bus_be = 1111, bus_addr = 0x100; stall high for 3 cycles; rd_valid with rd_data = 0xDEADBEEF in cycle 3.
- LB, addr 0x103, rdata 0x80123456 -> be = 1000, rd_data = 0xFFFFFF80. LBU, same address -> rd_data = 0x00000080.
- SH, addr 0x202, wdata 0x0000ABCD, ready delayed 4 cycles -> bus_req_valid held 4 cycles with stable fields, be = 1100, bus_wdata = 0xABCDABCD, rd_valid = 0.
- LW, addr 0x101 -> misalign pulse, no bus_req_valid, stall = 0. Size 011 -> fault pulse, no access.
- TIMEOUT = 8, resp never arrives -> fault pulse after 8 RESP cycles, then DONE and IDLE. A resp_err response -> fault, rd_valid = 0.
- rst_n low during RESP, then a stale bus_resp_valid arrives -> all outputs 0 and the response is ignored; the next LW completes normally.
